// File: rtl/micro_sequencer_if.sv
// Branch-control inputs and micro-PC/status outputs of micro_sequencer.
// The master modport drives microinstruction fields; the slave is the sequencer.
interface micro_sequencer_if #(
   parameter int UPC_W = 8
);
   logic             stall;
   logic [2:0]       br_op;
   logic [UPC_W-1:0] br_addr;
   logic [3:0]       cc_sel;
   logic [15:0]      cc;
   logic [5:0]       mw_sel;
   logic             resume;
   logic [UPC_W-1:0] upc;
   logic             halted;
   logic             mw_err;
   logic             stk_err;

   modport master (
      output stall, br_op, br_addr, cc_sel, cc, mw_sel, resume,
      input  upc, halted, mw_err, stk_err
   );

   modport slave (
      input  stall, br_op, br_addr, cc_sel, cc, mw_sel, resume,
      output upc, halted, mw_err, stk_err
   );
endinterface

// File: rtl/micro_sequencer.sv
// Microcode sequencer: computes the next micro-PC from branch op, condition flags and multiway requests.
// Optional return stack for CALL/RET is enabled by defining MSEQ_SUBROUTINE_EN.
module micro_sequencer #(
   parameter int UPC_W       = 8,
   parameter int STACK_DEPTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   micro_sequencer_if.slave bus
);
   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
   typedef enum logic [2:0] {
      OP_SEQ = 3'd0, OP_JMP = 3'd1, OP_BRT = 3'd2, OP_BRF = 3'd3,
      OP_MWAY = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_HALT = 3'd7
   } br_op_e;

   if (STACK_DEPTH < 1) begin : g_bad_depth
      $error("micro_sequencer: STACK_DEPTH must be at least 1");
   end

   // Lowest set request wins; targets wider than UPC_W lose their upper bits.
   function automatic logic [UPC_W-1:0] mway_target(input logic [5:0] sel);
      logic [5:0] t;
      if (sel[0])      t = 6'd0;
      else if (sel[1]) t = 6'd9;
      else if (sel[2]) t = 6'd17;
      else if (sel[3]) t = 6'd19;
      else if (sel[4]) t = 6'd41;
      else if (sel[5]) t = 6'd49;
      else             t = 6'd0;
      return UPC_W'(t);
   endfunction

   state_e           state_r, state_nx_s;
   logic [UPC_W-1:0] upc_r, upc_nx_s, upc_inc_s;
   logic             mw_err_r, mw_err_nx_s;
   logic             stk_err_r, stk_err_nx_s;
   br_op_e           op_s;
   logic             cc_bit_s;
   logic             mw_multi_s;

   assign op_s       = br_op_e'(bus.br_op);
   assign cc_bit_s   = bus.cc[bus.cc_sel];
   assign upc_inc_s  = upc_r + UPC_W'(1);
   assign mw_multi_s = |(bus.mw_sel & (bus.mw_sel - 6'd1));

`ifdef MSEQ_SUBROUTINE_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [SP_W-1:0]  sp_r;
   logic [UPC_W-1:0] stack_r [STACK_DEPTH];
   logic             push_s, pop_s, stk_full_s, stk_empty_s;
   logic [IDX_W-1:0] push_idx_s, pop_idx_s;

   assign stk_full_s  = (sp_r == SP_W'(STACK_DEPTH));
   assign stk_empty_s = (sp_r == SP_W'(0));
   assign push_idx_s  = IDX_W'(sp_r);
   assign pop_idx_s   = IDX_W'(sp_r - SP_W'(1));

   // Stack pointer: one push or one pop per unstalled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_r <= SP_W'(0);
      end else if (push_s) begin
         sp_r <= sp_r + SP_W'(1);
      end else if (pop_s) begin
         sp_r <= sp_r - SP_W'(1);
      end else begin
         sp_r <= sp_r;
      end
   end

   // Return-address storage; entries above sp_r are don't-care so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[push_idx_s] <= upc_inc_s;
      end
   end
`endif

   // Next-state, next-upc and error-pulse decode.
   always_comb begin
      state_nx_s   = state_r;
      upc_nx_s     = upc_r;
      mw_err_nx_s  = 1'b0;
      stk_err_nx_s = 1'b0;
`ifdef MSEQ_SUBROUTINE_EN
      push_s       = 1'b0;
      pop_s        = 1'b0;
`endif
      if (bus.stall) begin
         state_nx_s = state_r;
         upc_nx_s   = upc_r;
      end else begin
         case (state_r)
            ST_RUN: begin
               case (op_s)
                  OP_SEQ: upc_nx_s = upc_inc_s;
                  OP_JMP: upc_nx_s = bus.br_addr;
                  OP_BRT: upc_nx_s = cc_bit_s ? bus.br_addr : upc_inc_s;
                  OP_BRF: upc_nx_s = cc_bit_s ? upc_inc_s : bus.br_addr;
                  OP_MWAY: begin
                     if (bus.mw_sel == 6'd0) begin
                        upc_nx_s    = upc_inc_s;
                        mw_err_nx_s = 1'b1;
                     end else begin
                        upc_nx_s    = mway_target(bus.mw_sel);
                        mw_err_nx_s = mw_multi_s;
                     end
                  end
`ifdef MSEQ_SUBROUTINE_EN
                  OP_CALL: begin
                     upc_nx_s = bus.br_addr;
                     if (stk_full_s) begin
                        stk_err_nx_s = 1'b1;
                     end else begin
                        push_s = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (stk_empty_s) begin
                        upc_nx_s     = UPC_W'(0);
                        stk_err_nx_s = 1'b1;
                     end else begin
                        upc_nx_s = stack_r[pop_idx_s];
                        pop_s    = 1'b1;
                     end
                  end
`else
                  OP_CALL: upc_nx_s = bus.br_addr;
                  OP_RET:  upc_nx_s = upc_inc_s;
`endif
                  OP_HALT: state_nx_s = ST_HALT;
                  default: upc_nx_s = upc_r;
               endcase
            end
            ST_HALT: begin
               if (bus.resume) begin
                  state_nx_s = ST_RUN;
                  upc_nx_s   = upc_inc_s;
               end else begin
                  state_nx_s = ST_HALT;
               end
            end
            default: state_nx_s = ST_RUN;
         endcase
      end
   end

   // State, micro-PC and error pulses update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_RUN;
         upc_r     <= UPC_W'(0);
         mw_err_r  <= 1'b0;
         stk_err_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         upc_r     <= upc_nx_s;
         mw_err_r  <= mw_err_nx_s;
         stk_err_r <= stk_err_nx_s;
      end
   end

   assign bus.upc     = upc_r;
   assign bus.halted  = (state_r == ST_HALT);
   assign bus.mw_err  = mw_err_r;
   assign bus.stk_err = stk_err_r;
endmodule

// File: tb/tb_micro_sequencer.sv
// Table-driven bench for micro_sequencer with a queue scoreboard of expected outputs.
module tb_micro_sequencer;
   localparam int UPC_W = 8;
   localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                          MWAY = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

   typedef struct {
      logic        stall;
      logic [2:0]  op;
      logic [7:0]  addr;
      logic [3:0]  ccs;
      logic [15:0] cc;
      logic [5:0]  mw;
      logic        resume;
      logic [7:0]  e_upc;
      logic        e_halt;
      logic        e_mw;
      logic        e_stk;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   micro_sequencer_if #(.UPC_W(UPC_W)) bus ();

   micro_sequencer #(.UPC_W(UPC_W), .STACK_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic vec_t mk(input logic st, input logic [2:0] op, input logic [7:0] addr,
                               input logic [3:0] ccs, input logic [15:0] cc, input logic [5:0] mw,
                               input logic res, input logic [7:0] eu, input logic eh,
                               input logic em, input logic es);
      vec_t v;
      v.stall = st; v.op = op; v.addr = addr; v.ccs = ccs; v.cc = cc; v.mw = mw;
      v.resume = res; v.e_upc = eu; v.e_halt = eh; v.e_mw = em; v.e_stk = es;
      return v;
   endfunction

   task automatic cmp(input string tag, input int idx, input string fld, input int act, input int exp_v);
      if (act != exp_v) begin
         n_miss++;
         $display("FAIL %s #%0d %s: got %0d, expected %0d", tag, idx, fld, act, exp_v);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.stall  = v.stall;
      bus.br_op  = v.op;
      bus.br_addr = v.addr;
      bus.cc_sel = v.ccs;
      bus.cc     = v.cc;
      bus.mw_sel = v.mw;
      bus.resume = v.resume;
      exp_q.push_back(v);
   endtask

   task automatic check_out(input string tag, input int idx);
      vec_t e;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL %s #%0d scoreboard: got empty queue, expected an entry", tag, idx);
      end else begin
         e = exp_q.pop_front();
         n_vec++;
         cmp(tag, idx, "upc",     int'(bus.upc),     int'(e.e_upc));
         cmp(tag, idx, "halted",  int'(bus.halted),  int'(e.e_halt));
         cmp(tag, idx, "mw_err",  int'(bus.mw_err),  int'(e.e_mw));
         cmp(tag, idx, "stk_err", int'(bus.stk_err), int'(e.e_stk));
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      drive(v);
      @(posedge clk);
      #1;
      check_out(tag, idx);
   endtask

   task automatic expect_now(input logic [7:0] eu, input logic eh, input string tag, input int idx);
      exp_q.push_back(mk(1'b0, SEQ, 8'd0, 4'd0, 16'd0, 6'd0, 1'b0, eu, eh, 1'b0, 1'b0));
      check_out(tag, idx);
   endtask

   initial begin
      // stall op addr ccs cc mw resume | upc halted mw_err stk_err
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd1,   0, 0, 0));
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd2,   0, 0, 0));
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd3,   0, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd5,   4'd0,  16'h0000, 6'b000000, 0, 8'd5,   0, 0, 0));
      tbl.push_back(mk(0, BRT,  8'd40,  4'd3,  16'h0008, 6'b000000, 0, 8'd40,  0, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd5,   4'd0,  16'h0000, 6'b000000, 0, 8'd5,   0, 0, 0));
      tbl.push_back(mk(0, BRT,  8'd40,  4'd3,  16'hFFF7, 6'b000000, 0, 8'd6,   0, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd5,   4'd0,  16'h0000, 6'b000000, 0, 8'd5,   0, 0, 0));
      tbl.push_back(mk(0, BRF,  8'd40,  4'd3,  16'h0000, 6'b000000, 0, 8'd40,  0, 0, 0));
      tbl.push_back(mk(0, BRF,  8'd70,  4'd3,  16'h0008, 6'b000000, 0, 8'd41,  0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b000100, 0, 8'd17,  0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b110000, 0, 8'd41,  0, 1, 0));
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd42,  0, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd7,   4'd0,  16'h0000, 6'b000000, 0, 8'd7,   0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd8,   0, 1, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b000010, 0, 8'd9,   0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b001000, 0, 8'd19,  0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b100000, 0, 8'd49,  0, 0, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b111111, 0, 8'd0,   0, 1, 0));
      tbl.push_back(mk(0, MWAY, 8'd0,   4'd0,  16'h0000, 6'b010000, 0, 8'd41,  0, 0, 0));
      tbl.push_back(mk(0, BRT,  8'd200, 4'd15, 16'h8000, 6'b000000, 0, 8'd200, 0, 0, 0));
      tbl.push_back(mk(0, BRF,  8'd10,  4'd0,  16'hFFFE, 6'b000000, 0, 8'd10,  0, 0, 0));
      tbl.push_back(mk(0, HALT, 8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd10,  1, 0, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, JMP, 8'd99, 4'd0, 16'h0000, 6'b000000, 0, 8'd10, 1, 0, 0));
      tbl.push_back(mk(1, JMP,  8'd99,  4'd0,  16'h0000, 6'b000000, 1, 8'd10,  1, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd99,  4'd0,  16'h0000, 6'b000000, 1, 8'd11,  0, 0, 0));
      tbl.push_back(mk(0, JMP,  8'd255, 4'd0,  16'h0000, 6'b000000, 0, 8'd255, 0, 0, 0));
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd0,   0, 0, 0));
      tbl.push_back(mk(1, JMP,  8'd20,  4'd0,  16'h0000, 6'b000000, 0, 8'd0,   0, 0, 0));
      tbl.push_back(mk(1, MWAY, 8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd0,   0, 0, 0));
      tbl.push_back(mk(1, HALT, 8'd0,   4'd0,  16'h0000, 6'b000000, 0, 8'd0,   0, 0, 0));
      tbl.push_back(mk(0, SEQ,  8'd0,   4'd0,  16'h0000, 6'b000000, 1, 8'd1,   0, 0, 0));

      bus.stall = 1'b0; bus.br_op = SEQ; bus.br_addr = 8'd0; bus.cc_sel = 4'd0;
      bus.cc = 16'd0; bus.mw_sel = 6'd0; bus.resume = 1'b0;

      #2 rst_n = 1'b0;
      #1 expect_now(8'd0, 1'b0, "reset", 0);
      @(negedge clk) rst_n = 1'b1;

      foreach (tbl[i]) apply(tbl[i], "table", i);

      // Mid-cycle reset acts before the next edge; first edge afterwards runs address 0.
      apply(mk(0, JMP, 8'd77, 4'd0, 16'h0, 6'd0, 0, 8'd77, 0, 0, 0), "midreset", 0);
      #2 rst_n = 1'b0;
      #1 expect_now(8'd0, 1'b0, "midreset", 1);
      @(posedge clk);
      #1 expect_now(8'd0, 1'b0, "midreset", 2);
      @(negedge clk) rst_n = 1'b1;
      apply(mk(0, SEQ, 8'd0, 4'd0, 16'h0, 6'd0, 0, 8'd1, 0, 0, 0), "midreset", 3);

      // Reset while halted, and while an mw_err pulse is showing.
      apply(mk(0, JMP,  8'd30, 4'd0, 16'h0, 6'd0, 0, 8'd30, 0, 0, 0), "haltreset", 0);
      apply(mk(0, HALT, 8'd0,  4'd0, 16'h0, 6'd0, 0, 8'd30, 1, 0, 0), "haltreset", 1);
      rst_n = 1'b0;
      #1 expect_now(8'd0, 1'b0, "haltreset", 2);
      #2 rst_n = 1'b1;
      apply(mk(0, SEQ,  8'd0,  4'd0, 16'h0, 6'd0, 0, 8'd1, 0, 0, 0), "haltreset", 3);
      apply(mk(0, MWAY, 8'd0,  4'd0, 16'h0, 6'd0, 0, 8'd2, 0, 1, 0), "haltreset", 4);
      rst_n = 1'b0;
      #1 expect_now(8'd0, 1'b0, "haltreset", 5);
      #2 rst_n = 1'b1;
      apply(mk(0, SEQ,  8'd0,  4'd0, 16'h0, 6'd0, 0, 8'd1, 0, 0, 0), "haltreset", 6);

`ifdef MSEQ_SUBROUTINE_EN
      for (int i = 0; i < 4; i++)
         apply(mk(0, CALL, 8'd100, 4'd0, 16'h0, 6'd0, 0, 8'd100, 0, 0, 0), "call", i);
      apply(mk(0, CALL, 8'd100, 4'd0, 16'h0, 6'd0, 0, 8'd100, 0, 0, 1), "call", 4);
      for (int i = 0; i < 3; i++)
         apply(mk(0, RET, 8'd0, 4'd0, 16'h0, 6'd0, 0, 8'd101, 0, 0, 0), "ret", i);
      apply(mk(0, RET, 8'd0, 4'd0, 16'h0, 6'd0, 0, 8'd2, 0, 0, 0), "ret", 3);
      apply(mk(0, RET, 8'd0, 4'd0, 16'h0, 6'd0, 0, 8'd0, 0, 0, 1), "ret", 4);
      apply(mk(0, SEQ, 8'd0, 4'd0, 16'h0, 6'd0, 0, 8'd1, 0, 0, 0), "ret", 5);
`else
      apply(mk(0, CALL, 8'd100, 4'd0, 16'h0, 6'd0, 0, 8'd100, 0, 0, 0), "call", 0);
      apply(mk(0, RET,  8'd0,   4'd0, 16'h0, 6'd0, 0, 8'd101, 0, 0, 0), "ret", 0);
      apply(mk(0, RET,  8'd0,   4'd0, 16'h0, 6'd0, 0, 8'd102, 0, 0, 0), "ret", 1);
`endif

      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UPC_W, default 8: micro-PC width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries; used only with MSEQ_SUBROUTINE_EN.
REQ-003 clk  in  1: single clock; all state changes on rising edge.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 stall  in  1: hold all state this cycle.
REQ-006 br_op  in  3: current microinstruction branch op: 000 SEQ, 001 JMP, 010 BRT, 011 BRF, 100 MWAY, 101 CALL, 110 RET, 111 HALT.
REQ-007 br_addr  in  UPC_W: branch target field.
REQ-008 cc_sel  in  4: selects one bit of cc.
REQ-009 cc  in  16: condition flags.
REQ-010 mw_sel  in  6: multiway branch requests; bit0..bit5 map to fixed targets 0, 9, 17, 19, 41, 49.
REQ-011 resume  in  1: leave HALT state.
REQ-012 upc  out  UPC_W: registered micro-PC, addresses the microcode ROM.
REQ-013 halted  out  1: high while in HALT state.
REQ-014 mw_err  out  1: one-cycle pulse on malformed multiway request.
REQ-015 stk_err  out  1: one-cycle pulse on return-stack overflow/underflow.

Function
REQ-016 FSM has two states, RUN and HALT; halted = (state == HALT).
REQ-017 Inputs are sampled in the cycle upc presents them; the new upc appears after the next rising edge (latency 1).
REQ-018 In RUN with stall=1: upc, state and stack hold; mw_err and stk_err are 0.
REQ-019 In RUN with stall=0: SEQ -> upc+1; JMP -> br_addr; BRT -> br_addr if cc[cc_sel]=1, else upc+1; BRF -> br_addr if cc[cc_sel]=0, else upc+1.
REQ-020 MWAY, exactly one mw_sel bit set -> that bit's fixed target.
REQ-021 MWAY, multiple bits set -> target of the lowest set index, plus mw_err pulse.
REQ-022 MWAY, no bits set -> upc+1, plus mw_err pulse.
REQ-023 HALT op -> upc holds, state goes to HALT.
REQ-024 In HALT: upc holds and br_op is ignored; resume=1 with stall=0 -> state RUN and upc+1 on the same edge.
REQ-025 stall takes priority over resume and over every br_op.
REQ-026 upc+1 wraps modulo 2^UPC_W (e.g. 255 -> 0 for UPC_W=8).
REQ-027 When UPC_W < 6, multiway targets are truncated to UPC_W bits.
REQ-028 Error pulses last exactly one cycle and are registered with the upc update.

Reset
REQ-029 rst_n=0 immediately forces upc=0, state=RUN, halted=0, mw_err=0, stk_err=0 and stack pointer=0, regardless of clk.
REQ-030 Reset mid-branch or mid-HALT discards all pending state; the first edge after deassertion executes the microinstruction at address 0.

Configuration
REQ-031 The macro MSEQ_SUBROUTINE_EN, when defined, adds a STACK_DEPTH-entry return stack.
REQ-032 With the macro defined, CALL pushes upc+1 and jumps to br_addr.
REQ-033 With the macro defined, RET pops the top entry into upc.
REQ-034 With the macro defined, CALL on a full stack jumps to br_addr without pushing and pulses stk_err.
REQ-035 With the macro defined, RET on an empty stack sets upc=0 and pulses stk_err.
REQ-036 With the macro undefined, CALL behaves as JMP, RET behaves as SEQ, stk_err is constant 0, and no stack storage exists.

Verification
REQ-037 Release reset with br_op=SEQ for 3 cycles -> upc goes 0,1,2,3; assert rst_n=0 mid-cycle -> upc=0 immediately, before the next edge.
REQ-038 upc=5, br_op=BRT, cc_sel=3, cc[3]=1, br_addr=40 -> upc=40; repeat with cc[3]=0 -> upc=6; BRF with cc[3]=0 -> upc=40.
REQ-039 MWAY with mw_sel=000100 -> upc=17, mw_err=0; mw_sel=110000 -> upc=41, mw_err=1 for one cycle; mw_sel=0 from upc=7 -> upc=8, mw_err=1.
REQ-040 upc=10, br_op=HALT -> halted=1 and upc stays 10 for 5 cycles despite JMP on br_op; resume=1 together with stall=1 -> no change; resume=1 with stall=0 -> upc=11, halted=0.
REQ-041 upc=255, SEQ -> upc=0; stall=1 during JMP to 20 -> upc unchanged.
REQ-042 With MSEQ_SUBROUTINE_EN: 4 nested CALLs from upc=1 to br_addr=100 succeed; a 5th CALL jumps with stk_err=1; 4 RETs return to the pushed addresses in LIFO order (first RET returns to 101); a 5th RET -> upc=0, stk_err=1.
